reg_dump_tx: RTL and testbench
==============================

// Module: reg_dump_tx
// PURPOSE
//  Debug reader for the CPU register-observe port. Sweeps the 3-bit register select (Inr)
//  over r0..r7 and samples the 16-bit OutValue. Sends a framed snapshot on a UART 8N1 line
//  so register contents can be checked off-chip.
//  Sits beside CPU: drives CPU.Inr, reads CPU.OutValue, and may be triggered by CPU.halt.
// PARAMETERS
//  CLKS_PER_BIT  16     clk cycles per serial bit (>=2)
//  NUM_REGS      8      registers swept, indices 0..NUM_REGS-1 (<=8)
//  DATA_W        16     OutValue width; sent as 2 bytes, MSB byte first
//  HDR_BYTE      8'hA5  frame header byte
// PORTS
//  clk       in   1   single system clock, all state updates on rising edge
//  reset     in   1   synchronous, active-low reset
//  start     in   1   request a dump; sampled only in IDLE
//  halt      in   1   CPU halt flag; a 0->1 edge in IDLE acts as start
//  OutValue  in   16  register value selected by Inr (combinational in CPU)
//  Inr       out  3   register select driven to CPU
//  tx        out  1   serial line, idle high
//  busy      out  1   high from first start-bit cycle to end of last stop bit
//  done      out  1   one-cycle pulse after last stop bit
// BEHAVIOUR
//  - Reset (reset==0 at edge): tx=1, Inr=0, busy=0, done=0, FSM=IDLE, counters=0.
//    halt edge detector is cleared. Reset wins over start in the same cycle.
//  - Reset mid-frame aborts the frame. tx=1 on the next cycle. No partial resume.
//  - Frame = HDR_BYTE, then for i=0..NUM_REGS-1: r[i][15:8], r[i][7:0]. Default 17 bytes.
//  - Byte format: start bit 0, 8 data bits LSB first, stop bit 1.
//    Each bit is held exactly CLKS_PER_BIT cycles.
//  - Bytes go back-to-back with no idle gap. busy lasts exactly 17*10*CLKS_PER_BIT cycles.
//  - Trigger at edge t in IDLE: tx=0 (header start bit) and busy=1 from edge t+1.
//  - Trigger while busy: ignored, not queued. A halt edge during busy is also dropped.
//  - Register fetch is prefetched, so it never stalls the line:
//      Inr=i is driven throughout the byte preceding r[i]'s MSB byte (header for i=0).
//      OutValue is captured into hold[15:0] on the last cycle of that byte's stop bit.
//      Inr is stable at least 10*CLKS_PER_BIT-1 cycles before capture.
//  - Snapshot is per register, not atomic. Benches dump a halted CPU.
//  - After the last stop bit: done=1 for one cycle, busy=0, Inr=0, FSM=IDLE.
//    A start in that same cycle is accepted (back-to-back dumps allowed).
//  - FSM states: IDLE -> HDR -> (HI -> LO) x NUM_REGS -> FIN -> IDLE.
//    Each byte state advances only when the serializer reports byte_done.
//  - Counters:
//      bit timer 0..CLKS_PER_BIT-1, wraps to 0
//      bit index 0..9
//      reg index 0..NUM_REGS-1, 3 bits, no wrap within a frame
// STRUCTURE
//  - Shared package (cpu_dbg_pkg): HDR_BYTE, dump FSM state encoding,
//    UART frame constants (start/stop levels, 10 bits per byte).
//  - One sub-module, uart_tx_byte:
//      inputs: load, byte[7:0]
//      outputs: tx, byte_done (1-cycle pulse on the last stop-bit cycle)
//      parameterised by CLKS_PER_BIT
//  - Top level holds the FSM, reg index, hold register, halt edge detect, and Inr/busy/done.
// TESTING (CLKS_PER_BIT=4; decoder in bench samples at mid-bit)
//  1. reset=0 for 2 cycles, start=1 -> tx=1, busy=0, Inr=0, done=0; no start bit.
//  2. r0..r7 = 16'h0000,1111,...,7777; pulse start
//     -> bytes A5 00 00 11 11 22 22 ... 77 77; busy high 680 cycles; done pulses once.
//  3. Registers = 16'h8001 each; check every bit width is exactly 4 cycles, start bit low,
//     stop bit high -> each reg decodes as bytes 80 01.
//  4. start pulsed at cycles 5, 100, 400 of a dump -> single 17-byte frame, one done pulse.
//  5. reset=0 in the middle of byte 6 -> tx=1 and busy=0 next cycle;
//     a new start yields a full frame from A5.
//  6. halt 0->1 in IDLE -> dump starts next cycle. halt held high -> no retrigger.
//     start and reset=0 in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug register-dump path.
//   HDR_BYTE_DEF     default frame header byte
//   UART_*           8N1 line levels and bits per serial byte
//   dump_state_e     dump FSM state encoding
package cpu_dbg_pkg;

  localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
  localparam logic       UART_START_LVL  = 1'b0;
  localparam logic       UART_STOP_LVL   = 1'b1;
  localparam int         UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_FIN
  } dump_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for a single byte.
//   clk        system clock
//   reset      synchronous, active-low
//   load       latch tx_byte and start its start bit on the next cycle;
//              may be asserted on the byte_done cycle for gap-free output
//   tx_byte    byte to send, LSB first
//   tx         serial line, idle high
//   byte_done  one-cycle pulse on the last cycle of the stop bit
module uart_tx_byte
  import cpu_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       byte_done
);

  localparam int              TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      B_LAST = 4'(UART_FRAME_BITS - 1);

  logic                       active;
  logic [TW-1:0]              timer;
  logic [3:0]                 bit_idx;
  logic [UART_FRAME_BITS-1:0] frame;

  assign byte_done = active && (bit_idx == B_LAST) && (timer == T_LAST);
  assign tx        = active ? frame[bit_idx] : UART_STOP_LVL;

  always_ff @(posedge clk) begin
    if (!reset) begin
      active  <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      frame   <= {UART_FRAME_BITS{UART_STOP_LVL}};
    end else if (load) begin
      active  <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      frame   <= {UART_STOP_LVL, tx_byte, UART_START_LVL};
    end else if (active) begin
      if (timer == T_LAST) begin
        timer <= '0;
        if (bit_idx == B_LAST) begin
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Register-dump reader: sweeps Inr over r0..r(NUM_REGS-1), samples OutValue
// and sends HDR_BYTE followed by each register MSB byte first over UART 8N1.
//   clk       system clock
//   reset     synchronous, active-low
//   start     dump request, honoured only when not busy
//   halt      CPU halt flag; a rising edge acts as start
//   OutValue  value of the register selected by Inr
//   Inr       register select to the CPU
//   tx        serial line, idle high
//   busy      high for the whole frame, start bit of header to last stop bit
//   done      one-cycle pulse after the last stop bit
module reg_dump_tx
  import cpu_dbg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         NUM_REGS     = 8,
  parameter int         DATA_W       = 16,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [DATA_W-1:0] OutValue,
  output logic [2:0]        Inr,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  dump_state_e state, state_nxt;
  logic        halt_q;
  logic        trig;
  logic [2:0]  reg_idx;
  logic [7:0]  hold_lo;
  logic        on_last;
  logic        byte_done;
  logic        u_load;
  logic [7:0]  u_byte;
  logic        capture;
  logic        step_idx;

  assign trig = start | (halt & ~halt_q);

  // The MSB byte goes straight from OutValue into the serializer on the
  // capture cycle, so only the LSB byte has to be held for the next byte.
  always_comb begin
    state_nxt = state;
    u_load    = 1'b0;
    u_byte    = HDR_BYTE;
    capture   = 1'b0;
    step_idx  = 1'b0;
    case (state)
      ST_IDLE, ST_FIN: begin
        // FIN behaves as idle so a dump can follow on the done cycle
        state_nxt = ST_IDLE;
        if (trig) begin
          state_nxt = ST_HDR;
          u_load    = 1'b1;
        end
      end
      ST_HDR: if (byte_done) begin
        state_nxt = ST_HI;
        u_load    = 1'b1;
        u_byte    = OutValue[DATA_W-1 -: 8];
        capture   = 1'b1;
      end
      ST_HI: if (byte_done) begin
        // Select the next register now so it is stable for the whole LO byte
        state_nxt = ST_LO;
        u_load    = 1'b1;
        u_byte    = hold_lo;
        step_idx  = 1'b1;
      end
      ST_LO: if (byte_done) begin
        if (on_last) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_HI;
          u_load    = 1'b1;
          u_byte    = OutValue[DATA_W-1 -: 8];
          capture   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      halt_q  <= 1'b0;
      reg_idx <= '0;
      hold_lo <= '0;
      on_last <= 1'b0;
    end else begin
      state  <= state_nxt;
      halt_q <= halt;
      if (capture)
        hold_lo <= OutValue[7:0];
      // reg_idx saturates on the last register; on_last marks its LO byte
      if (step_idx) begin
        if (reg_idx == LAST_IDX) on_last <= 1'b1;
        else                     reg_idx <= reg_idx + 3'd1;
      end
      if (state_nxt == ST_FIN) begin
        reg_idx <= '0;
        on_last <= 1'b0;
      end
    end
  end

  assign Inr  = reg_idx;
  assign busy = (state == ST_HDR) || (state == ST_HI) || (state == ST_LO);
  assign done = (state == ST_FIN);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (u_load),
    .tx_byte   (u_byte),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx with CLKS_PER_BIT=4. The line, busy, done and
// Inr are recorded once per cycle on the falling edge, then each dump trace is
// decoded against the byte stream expected from the register model.
module tb_reg_dump_tx;

  localparam int CPB    = 4;
  localparam int NREG   = 8;
  localparam int NBYTES = 1 + 2 * NREG;
  localparam int FRAME  = NBYTES * 10 * CPB;

  logic        clk, reset, start, halt;
  logic [15:0] OutValue;
  logic [2:0]  Inr;
  logic        tx, busy, done;

  logic [15:0] regs [NREG];
  logic [7:0]  exp_bytes [NBYTES];

  int n_chk, n_err;

  logic       rec;
  logic       tx_q[$];
  logic       busy_q[$];
  logic       done_q[$];
  logic [2:0] inr_q[$];

  assign OutValue = regs[Inr];

  reg_dump_tx #(
    .CLKS_PER_BIT (CPB),
    .NUM_REGS     (NREG),
    .DATA_W       (16),
    .HDR_BYTE     (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt     (halt),
    .OutValue (OutValue),
    .Inr      (Inr),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec) begin
      tx_q.push_back(tx);
      busy_q.push_back(busy);
      done_q.push_back(done);
      inr_q.push_back(Inr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp();
    exp_bytes[0] = 8'hA5;
    for (int i = 0; i < NREG; i++) begin
      exp_bytes[1 + 2 * i] = regs[i][15:8];
      exp_bytes[2 + 2 * i] = regs[i][7:0];
    end
  endtask

  // mode 0: start pulse, 1: start pulse plus extra starts mid-frame, 2: halt rise (held)
  task automatic dump_run(input int mode);
    tx_q.delete(); busy_q.delete(); done_q.delete(); inr_q.delete();
    @(posedge clk); #1;
    rec = 1'b1;
    if (mode == 2) halt = 1'b1;
    else           start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < FRAME + 80; c++) begin
      if (mode == 1 && (c == 5 || c == 100 || c == 400)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    rec = 1'b0;
  endtask

  task automatic analyze(input string tag);
    int bs, nbusy, ndone, dpos, viol, iviol, idx, sz;
    logic [7:0] got;
    logic ebit;
    sz = tx_q.size();
    bs = -1;
    for (int k = 0; k < sz; k++)
      if (busy_q[k] === 1'b1 && bs < 0) bs = k;
    chk({tag, " busy_start"}, bs, 1);
    if (bs < 0 || bs > 20) bs = 1;
    if (sz < bs + FRAME + 1) begin
      chk({tag, " trace_len"}, sz, bs + FRAME + 1);
      return;
    end
    nbusy = 0; ndone = 0; dpos = -1;
    for (int k = 0; k < sz; k++) begin
      if (busy_q[k] === 1'b1) nbusy++;
      if (done_q[k] === 1'b1) begin
        ndone++;
        if (dpos < 0) dpos = k;
      end
    end
    chk({tag, " busy_len"}, nbusy, FRAME);
    chk({tag, " done_cnt"}, ndone, 1);
    chk({tag, " done_pos"}, dpos, bs + FRAME);
    viol = 0;
    for (int b = 0; b < NBYTES; b++) begin
      got = 8'h00;
      for (int j = 0; j < 10; j++) begin
        idx  = bs + (b * 10 + j) * CPB;
        ebit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_bytes[b][j-1];
        if (j >= 1 && j <= 8) got[j-1] = tx_q[idx + CPB / 2];
        for (int s = 0; s < CPB; s++)
          if (tx_q[idx + s] !== ebit) viol++;
      end
      chk($sformatf("%s byte%0d", tag, b), got, exp_bytes[b]);
    end
    chk({tag, " bit_cells"}, viol, 0);
    // Inr=i must be held across the byte just before r[i]'s MSB byte
    iviol = 0;
    for (int i = 0; i < NREG; i++)
      for (int s = 0; s < 10 * CPB; s++)
        if (inr_q[bs + 2 * i * 10 * CPB + s] !== 3'(i)) iviol++;
    chk({tag, " inr_prefetch"}, iviol, 0);
    chk({tag, " tx_idle_after"}, tx_q[bs + FRAME + 1], 1);
  endtask

  initial begin
    int cnt;
    n_chk = 0; n_err = 0;
    rec = 1'b0; halt = 1'b0;
    reset = 1'b0; start = 1'b1;
    for (int i = 0; i < NREG; i++) regs[i] = 16'h0000;

    // 1: reset held with start high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst tx",   tx,   1);
    chk("rst busy", busy, 0);
    chk("rst Inr",  Inr,  0);
    chk("rst done", done, 0);
    reset = 1'b1; start = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    chk("rst no_frame", cnt, 0);

    // 2: r[i] = 16'h1111*i
    for (int i = 0; i < NREG; i++) regs[i] = 16'(16'h1111 * i);
    build_exp();
    dump_run(0);
    analyze("t2");
    chk("t2 Inr_end", Inr, 0);

    // 3: all registers 16'h8001
    for (int i = 0; i < NREG; i++) regs[i] = 16'h8001;
    build_exp();
    dump_run(0);
    analyze("t3");

    // 4: extra start pulses while busy are dropped
    for (int i = 0; i < NREG; i++) regs[i] = 16'(16'h1111 * i);
    build_exp();
    dump_run(1);
    analyze("t4");

    // 5: reset landing on byte 6's start bit aborts the frame
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (240) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5 abort tx",   tx,   1);
    chk("t5 abort busy", busy, 0);
    chk("t5 abort Inr",  Inr,  0);
    #1; reset = 1'b1;
    repeat (3) @(posedge clk);
    dump_run(0);
    analyze("t5");

    // 6: halt rising edge triggers once while held high
    dump_run(2);
    analyze("t6");
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt++;
    end
    chk("t6 halt_held", cnt, 0);
    halt = 1'b0;

    // start coincident with reset: reset wins
    @(posedge clk); #1; start = 1'b1; reset = 1'b0;
    @(posedge clk); #1; start = 1'b0; reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) cnt++;
    end
    chk("t6 rst_over_start", cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
